// File: rtl/elevator_dispatch.sv
// Single-car LOOK dispatcher: consumes the latched request vector, steps the car
// floor by floor with a move timer, dwells with the door open and clears serviced floors.
module elevator_dispatch #(
    parameter int MOVE_CYCLES = 4,
    parameter int DOOR_CYCLES = 3,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic       req_flag,
    output logic [7:0] clr,
    output logic [2:0] floor,
    output logic       dir_up,
    output logic       moving,
    output logic       door_open,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MOVE = 2'd1,
        S_DOOR = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MOVE_LOAD = CNT_W'(MOVE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DOOR_LOAD = CNT_W'(DOOR_CYCLES - 1);

    state_t           state_q, state_d;
    logic [2:0]       floor_q, floor_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [7:0] r;
    logic [7:0] above, below;
    logic       here;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            floor_q <= 3'd0;
            dir_q   <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            floor_q <= floor_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        r     = req_flag ? req : 8'h00;
        above = '0;
        below = '0;
        for (int i = 0; i < 8; i++) begin
            above[i] = r[i] && (i > 32'(floor_q));
            below[i] = r[i] && (i < 32'(floor_q));
        end
        here = r[floor_q];
    end

    // NOTE: every next-state signal gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        floor_d = floor_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (here) begin
                    state_d = S_DOOR;
                    cnt_d   = DOOR_LOAD;
                end else if (dir_q && (above != 8'h00)) begin
                    state_d = S_MOVE;
                    cnt_d   = MOVE_LOAD;
                end else if (!dir_q && (below != 8'h00)) begin
                    state_d = S_MOVE;
                    cnt_d   = MOVE_LOAD;
                end else if (above != 8'h00) begin
                    state_d = S_MOVE;
                    dir_d   = 1'b1;
                    cnt_d   = MOVE_LOAD;
                end else if (below != 8'h00) begin
                    state_d = S_MOVE;
                    dir_d   = 1'b0;
                    cnt_d   = MOVE_LOAD;
                end
            end
            S_MOVE: begin
                if (cnt_q == '0) begin
                    // Direction was validated on entry, so the step cannot leave 0..7.
                    floor_d = dir_q ? floor_q + 3'd1 : floor_q - 3'd1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DOOR: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs depend only on registered state, keeping the clr-to-latch path loop-free.
    assign clr       = (state_q == S_DOOR) ? (8'd1 << floor_q) : 8'h00;
    assign moving    = (state_q == S_MOVE);
    assign door_open = (state_q == S_DOOR);
    assign floor     = floor_q;
    assign dir_up    = dir_q;
    assign state     = state_q;

endmodule

// File: tb/tb_elevator_dispatch.sv
// Bench for elevator_dispatch: emulates the request latch, tracks the car with a
// behavioural model compared every cycle, and pins key moments with literal expectations.
module tb_elevator_dispatch;

    localparam int MOVE_CYCLES = 4;
    localparam int DOOR_CYCLES = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] req_l = 8'h00;
    logic       req_flag = 1'b0;
    logic [7:0] clr;
    logic [2:0] floor;
    logic       dir_up, moving, door_open;
    logic [1:0] state;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    elevator_dispatch #(.MOVE_CYCLES(MOVE_CYCLES), .DOOR_CYCLES(DOOR_CYCLES), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .req(req_l), .req_flag(req_flag),
        .clr(clr), .floor(floor), .dir_up(dir_up), .moving(moving),
        .door_open(door_open), .state(state)
    );

    always #5 clk = ~clk;

    // Model: phase 0 idle, 1 travelling, 2 door; elapsed counts cycles spent in the phase.
    typedef struct packed {
        logic [1:0] phase;
        logic [2:0] flr;
        logic       dir;
        logic [7:0] elapsed;
    } model_t;

    model_t m = '{phase: 2'd0, flr: 3'd0, dir: 1'b1, elapsed: 8'd0};

    function automatic model_t model_step(model_t cur, logic rst, logic [7:0] rq, logic fl);
        model_t nx;
        int rv, f;
        bit any_above, any_below, at_here, go_up;
        nx = cur;
        rv = fl ? int'(rq) : 0;
        f  = int'(cur.flr);
        any_above = (rv >> (f + 1)) != 0;
        any_below = (rv & ((1 << f) - 1)) != 0;
        at_here   = ((rv >> f) & 1) != 0;
        if (!rst) begin
            nx = '{phase: 2'd0, flr: 3'd0, dir: 1'b1, elapsed: 8'd0};
        end else if (cur.phase == 2'd0) begin
            go_up = any_above && (cur.dir || !any_below);
            if (at_here) begin
                nx.phase = 2'd2;
                nx.elapsed = 8'd0;
            end else if (any_above || any_below) begin
                nx.phase = 2'd1;
                nx.dir = go_up;
                nx.elapsed = 8'd0;
            end
        end else if (cur.phase == 2'd1) begin
            if (int'(cur.elapsed) == MOVE_CYCLES - 1) begin
                nx.flr = 3'(cur.dir ? f + 1 : f - 1);
                nx.phase = 2'd0;
            end else begin
                nx.elapsed = cur.elapsed + 8'd1;
            end
        end else begin
            if (int'(cur.elapsed) == DOOR_CYCLES - 1) nx.phase = 2'd0;
            else nx.elapsed = cur.elapsed + 8'd1;
        end
        return nx;
    endfunction

    always @(posedge clk) m <= model_step(m, reset, req_l, req_flag);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("state", 32'(state), 32'(m.phase));
            check("floor", 32'(floor), 32'(m.flr));
            check("dir_up", 32'(dir_up), 32'(m.dir));
            check("moving", 32'(moving), 32'(m.phase == 2'd1));
            check("door_open", 32'(door_open), 32'(m.phase == 2'd2));
            check("clr", 32'(clr), (m.phase == 2'd2) ? (32'd1 << m.flr) : 32'd0);
        end
    end

    // Advance one cycle; the emulated latch drops any floor the car is clearing.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req_l = req_l & ~clr;
        end
    endtask

    task automatic wait_clr(input logic [7:0] want, input int budget, input string name);
        for (int i = 0; i < budget && clr !== want; i++) tick();
        check(name, 32'(clr), 32'(want));
    endtask

    task automatic wait_moving_at(input logic [2:0] f, input int budget, input string name);
        for (int i = 0; i < budget && !(floor === f && moving === 1'b1); i++) tick();
        check(name, 32'(floor), 32'(f));
        check({name, "_moving"}, 32'(moving), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset and quiescent hold
        reset = 1'b0;
        tick(2);
        chk_en = 1'b1;
        reset = 1'b1;
        tick(10);
        check("t1_state", 32'(state), 32'd0);
        check("t1_floor", 32'(floor), 32'd0);
        check("t1_dir", 32'(dir_up), 32'd1);
        check("t1_clr", 32'(clr), 32'h00);
        check("t1_door", 32'(door_open), 32'd0);

        // 2: request at current floor, door for exactly 3 cycles
        req_l = 8'h01;
        req_flag = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_door", 32'(door_open), 32'd1);
            check("t2_clr", 32'(clr), 32'h01);
        end
        tick();
        check("t2_after_state", 32'(state), 32'd0);
        check("t2_after_clr", 32'(clr), 32'h00);

        // 3: travel 0 -> 5, five cycles per floor
        req_l = 8'h20;
        tick(5);
        check("t3_floor1", 32'(floor), 32'd1);
        tick(20);
        check("t3_floor5", 32'(floor), 32'd5);
        check("t3_idle", 32'(state), 32'd0);
        tick();
        check("t3_door", 32'(door_open), 32'd1);
        check("t3_clr", 32'(clr), 32'h20);
        check("t3_dir", 32'(dir_up), 32'd1);
        tick(3);

        // 4: LOOK sweep: up to 3 then 6, then reverse to 1
        reset = 1'b0;
        tick();
        reset = 1'b1;
        req_l = 8'h08;
        wait_moving_at(3'd2, 40, "t4_at2");
        req_l = req_l | 8'h42;
        wait_clr(8'h08, 20, "t4_clr3");
        wait_clr(8'h40, 40, "t4_clr6");
        check("t4_dir_up", 32'(dir_up), 32'd1);
        wait_clr(8'h02, 60, "t4_clr1");
        check("t4_dir_down", 32'(dir_up), 32'd0);
        tick(3);

        // 5: reset mid-move returns the car to floor 0, then it heads for 7
        req_l = 8'h80;
        wait_moving_at(3'd2, 60, "t5_at2");
        reset = 1'b0;
        tick();
        check("t5_floor", 32'(floor), 32'd0);
        check("t5_state", 32'(state), 32'd0);
        check("t5_moving", 32'(moving), 32'd0);
        check("t5_clr", 32'(clr), 32'h00);
        reset = 1'b1;
        wait_clr(8'h80, 80, "t5_clr7");
        check("t5_floor7", 32'(floor), 32'd7);
        tick(3);

        // 6: requests masked by a low flag are ignored
        req_l = 8'hFF;
        req_flag = 1'b0;
        tick(15);
        check("t6_state", 32'(state), 32'd0);
        check("t6_floor", 32'(floor), 32'd7);
        check("t6_clr", 32'(clr), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
